// File: rtl/ofs_plat_avalon_mem_rdwr_credit_fence_ctrl_if.sv
// ofs_plat_avalon_mem_rdwr_credit_fence_ctrl_if
//
// Handshake-only view of an Avalon read/write memory port. Address, data
// and byte-enable buses travel outside this bundle. Burstcount and the
// write user flags are included because flow control depends on them.
//
// Modports:
//   master  issues requests (read, write, burstcount, user) and receives
//           waitrequest, readdatavalid and writeresponsevalid.
//   slave   the mirror image: accepts requests and returns the stall and
//           response strobes.
interface ofs_plat_avalon_mem_rdwr_credit_fence_ctrl_if #(
  parameter int BURST_CNT_WIDTH = 7,
  parameter int USER_WIDTH      = 8
);
  logic                       rd_read;
  logic [BURST_CNT_WIDTH-1:0] rd_burstcount;
  logic                       rd_waitrequest;
  logic                       rd_readdatavalid;

  logic                       wr_write;
  logic [BURST_CNT_WIDTH-1:0] wr_burstcount;
  logic [USER_WIDTH-1:0]      wr_user;
  logic                       wr_waitrequest;
  logic                       wr_writeresponsevalid;

  modport master (
    output rd_read, rd_burstcount, wr_write, wr_burstcount, wr_user,
    input  rd_waitrequest, rd_readdatavalid, wr_waitrequest, wr_writeresponsevalid
  );

  modport slave (
    input  rd_read, rd_burstcount, wr_write, wr_burstcount, wr_user,
    output rd_waitrequest, rd_readdatavalid, wr_waitrequest, wr_writeresponsevalid
  );
endinterface

// File: rtl/ofs_plat_avalon_mem_rdwr_credit_fence_ctrl.sv
// ofs_plat_avalon_mem_rdwr_credit_fence_ctrl
//
// Flow-control sequencer between an AFU-side Avalon read/write source and a
// host-memory sink. New read bursts are gated on a line-credit budget, new
// write bursts on a burst-credit budget. A write fence (SOP with the fence
// user bit set) is held until every earlier write has completed, issued
// alone, and later writes are held until the fence's own response returns.
//
// Ports:
//   clk, reset_n       clock and asynchronous active-low reset
//   src                slave side facing the AFU source
//   snk                master side facing the host-memory sink
//   rd_lines_active    outstanding read lines
//   wr_bursts_active   outstanding write bursts
//   fence_busy         fence sequencer is not idle
//   err_fence_burst    sticky: a fence arrived with burstcount != 1
module ofs_plat_avalon_mem_rdwr_credit_fence_ctrl #(
  parameter int BURST_CNT_WIDTH       = 7,
  parameter int USER_WIDTH            = 8,
  parameter int FENCE_BIT             = 0,
  parameter int MAX_ACTIVE_RD_LINES   = 256,
  parameter int MAX_ACTIVE_WR_BURSTS  = 64,
  parameter int BLOCK_WRITE_WITH_READ = 0
) (
  input  logic clk,
  input  logic reset_n,
  ofs_plat_avalon_mem_rdwr_credit_fence_ctrl_if.slave  src,
  ofs_plat_avalon_mem_rdwr_credit_fence_ctrl_if.master snk,
  output logic [$clog2(MAX_ACTIVE_RD_LINES+1)-1:0]  rd_lines_active,
  output logic [$clog2(MAX_ACTIVE_WR_BURSTS+1)-1:0] wr_bursts_active,
  output logic fence_busy,
  output logic err_fence_burst
);

  localparam int RD_CNT_W = $clog2(MAX_ACTIVE_RD_LINES+1);
  localparam int WR_CNT_W = $clog2(MAX_ACTIVE_WR_BURSTS+1);
  // Wide enough that count + burstcount (or count + max burst) never wraps.
  localparam int SUM_W    = RD_CNT_W + BURST_CNT_WIDTH;

  localparam logic [SUM_W-1:0]    RD_MAX    = SUM_W'(MAX_ACTIVE_RD_LINES);
  localparam logic [SUM_W-1:0]    MAX_BURST = SUM_W'(1 << (BURST_CNT_WIDTH-1));
  localparam logic [WR_CNT_W-1:0] WR_MAX    = WR_CNT_W'(MAX_ACTIVE_WR_BURSTS);

  typedef enum logic [1:0] {
    FENCE_IDLE,
    FENCE_DRAIN,
    FENCE_WAIT
  } fence_state_e;

  fence_state_e state, state_next;

  logic [SUM_W-1:0]           rd_sum;
  logic                       rd_ok, rd_accept;
  logic [RD_CNT_W-1:0]        rd_next;

  logic [BURST_CNT_WIDTH-1:0] beats_left;
  logic                       wr_sop, wr_accept, wr_sop_accept;
  logic                       is_fence, fence_sop;
  logic                       credit_ok, rd_room_ok, fsm_ok, sop_ok;
  logic [WR_CNT_W-1:0]        wr_next;

  // Payload-related fields and response strobes pass straight through.
  assign snk.rd_burstcount         = src.rd_burstcount;
  assign snk.wr_burstcount         = src.wr_burstcount;
  assign snk.wr_user               = src.wr_user;
  assign src.rd_readdatavalid      = snk.rd_readdatavalid;
  assign src.wr_writeresponsevalid = snk.wr_writeresponsevalid;

  // Read gate: a burst may only enter if all its lines fit in the budget.
  assign rd_sum             = SUM_W'(rd_lines_active) + SUM_W'(src.rd_burstcount);
  assign rd_ok              = (rd_sum <= RD_MAX);
  assign snk.rd_read        = src.rd_read & rd_ok;
  assign src.rd_waitrequest = snk.rd_waitrequest | ~rd_ok;
  assign rd_accept          = snk.rd_read & ~snk.rd_waitrequest;

  // Net read-line count; an accepted burst in the same cycle covers a
  // returning line, otherwise a return at zero saturates.
  always_comb begin
    rd_next = rd_lines_active;
    if (rd_accept)
      rd_next = rd_lines_active + RD_CNT_W'(src.rd_burstcount);
    if (snk.rd_readdatavalid && (rd_next != '0))
      rd_next = rd_next - RD_CNT_W'(1);
  end

  // Write SOP qualification. Only SOP beats are gated; mid-burst beats
  // always follow the sink so a started burst can never be stranded.
  assign wr_sop     = (beats_left == '0);
  assign is_fence   = src.wr_user[FENCE_BIT];
  assign fence_sop  = src.wr_write & wr_sop & is_fence;
  assign credit_ok  = (wr_bursts_active < WR_MAX);
  assign rd_room_ok = (BLOCK_WRITE_WITH_READ == 0) ||
                      ((SUM_W'(rd_lines_active) + MAX_BURST) <= RD_MAX);
  assign sop_ok     = credit_ok & rd_room_ok & fsm_ok;

  assign snk.wr_write       = src.wr_write & (~wr_sop | sop_ok);
  assign src.wr_waitrequest = snk.wr_waitrequest | (wr_sop & ~sop_ok);
  assign wr_accept          = snk.wr_write & ~snk.wr_waitrequest;
  assign wr_sop_accept      = wr_accept & wr_sop;

  // Net write-burst count with saturation at zero.
  always_comb begin
    wr_next = wr_bursts_active;
    if (wr_sop_accept)
      wr_next = wr_bursts_active + WR_CNT_W'(1);
    if (snk.wr_writeresponsevalid && (wr_next != '0))
      wr_next = wr_next - WR_CNT_W'(1);
  end

  // Fence permission for the current SOP. Kept apart from the next-state
  // logic because the next state depends on acceptance, which depends on
  // this permission.
  always_comb begin
    fsm_ok = 1'b0;
    case (state)
      FENCE_IDLE:  fsm_ok = ~is_fence;
      FENCE_DRAIN: fsm_ok = is_fence && (wr_bursts_active == '0);
      default:     fsm_ok = 1'b0;
    endcase
  end

  // Fence next state. WAIT exits on the edge where the count reaches zero,
  // so the freed slot is usable in the following cycle. DRAIN falls back to
  // IDLE if the source stops presenting the fence.
  always_comb begin
    state_next = state;
    case (state)
      FENCE_IDLE: begin
        if (fence_sop)
          state_next = FENCE_DRAIN;
      end
      FENCE_DRAIN: begin
        if (!fence_sop)
          state_next = FENCE_IDLE;
        else if (wr_accept)
          state_next = FENCE_WAIT;
      end
      FENCE_WAIT: begin
        if (wr_next == '0)
          state_next = FENCE_IDLE;
      end
      default: state_next = FENCE_IDLE;
    endcase
  end

  // State, counters, burst tracking and the sticky fence error.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= FENCE_IDLE;
      rd_lines_active  <= '0;
      wr_bursts_active <= '0;
      beats_left       <= '0;
      err_fence_burst  <= 1'b0;
    end else begin
      state            <= state_next;
      rd_lines_active  <= rd_next;
      wr_bursts_active <= wr_next;
      if (wr_accept) begin
        if (!wr_sop)
          beats_left <= beats_left - BURST_CNT_WIDTH'(1);
        else if (src.wr_burstcount != '0)
          beats_left <= src.wr_burstcount - BURST_CNT_WIDTH'(1);
        else
          beats_left <= '0;
      end
      if (fence_sop && (src.wr_burstcount != BURST_CNT_WIDTH'(1)))
        err_fence_burst <= 1'b1;
    end
  end

  assign fence_busy = (state != FENCE_IDLE);

  // A response while nothing is outstanding means the sink or source broke
  // protocol; the hardware saturates but simulation must stop loudly.
  rd_underflow: assert property (@(posedge clk) disable iff (!reset_n)
    !(snk.rd_readdatavalid && !rd_accept && (rd_lines_active == '0)))
    else $fatal(1, "read line counter underflow");

  wr_underflow: assert property (@(posedge clk) disable iff (!reset_n)
    !(snk.wr_writeresponsevalid && !wr_sop_accept && (wr_bursts_active == '0)))
    else $fatal(1, "write burst counter underflow");

endmodule
